// File: rtl/lvds_rx_aligner.sv
// Word aligner for an 8-bit LVDS deserializer: bit-slips until TRAIN_WORD is seen MATCH_CNT times in a row, then forwards payload.
// Define SEQ_CHECK_EN to add the payload sequence checker that drives err_cnt; otherwise err_cnt is tied to 0.
module lvds_rx_aligner #(
  parameter logic [7:0] TRAIN_WORD = 8'hF0,
  parameter int         MATCH_CNT  = 16,
  parameter int         SLIP_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_locked,
  input  logic [7:0]  rx_data,
  output logic        rx_data_align,
  output logic        align_done,
  output logic        align_fail,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [15:0] err_cnt
);

  localparam int MW = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CNT - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, CHECK, SLIP, ALIGNED} state_t;

  state_t          state;
  logic [MW-1:0]   match_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [2:0]      slip_cnt;
  logic            slip_phase;
  logic            fwd;

  // A payload word is forwarded only while aligned; training words are always dropped.
  assign fwd = (state == ALIGNED) && rx_locked && (rx_data != TRAIN_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      match_cnt     <= '0;
      wait_cnt      <= '0;
      slip_cnt      <= '0;
      slip_phase    <= 1'b0;
      rx_data_align <= 1'b0;
      align_done    <= 1'b0;
      align_fail    <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
    end else if (!rx_locked) begin
      // Lock loss restarts alignment from scratch; align_fail stays sticky.
      state         <= IDLE;
      match_cnt     <= '0;
      wait_cnt      <= '0;
      slip_cnt      <= '0;
      slip_phase    <= 1'b0;
      rx_data_align <= 1'b0;
      align_done    <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          match_cnt <= '0;
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        CHECK: begin
          if (rx_data == TRAIN_WORD) begin
            if (match_cnt == MATCH_LAST) begin
              state      <= ALIGNED;
              align_done <= 1'b1;
              align_fail <= 1'b0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end else begin
            state         <= SLIP;
            rx_data_align <= 1'b1;
            slip_phase    <= 1'b0;
            slip_cnt      <= slip_cnt + 3'd1;
            // Eighth slip means every rotation has been tried once.
            if (slip_cnt == 3'd7) align_fail <= 1'b1;
          end
        end
        SLIP: begin
          if (slip_phase) begin
            state         <= WAIT;
            rx_data_align <= 1'b0;
            slip_phase    <= 1'b0;
            wait_cnt      <= '0;
          end else begin
            slip_phase <= 1'b1;
          end
        end
        ALIGNED: begin
          data_valid <= fwd;
          if (fwd) data_out <= rx_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_CHECK_EN
  logic        seq_seeded;
  logic [7:0]  seq_prev;
  logic [15:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_seeded <= 1'b0;
      seq_prev   <= '0;
      err_q      <= '0;
    end else if (!rx_locked || state != ALIGNED) begin
      seq_seeded <= 1'b0;
    end else if (fwd) begin
      seq_seeded <= 1'b1;
      seq_prev   <= rx_data;
      if (seq_seeded && (rx_data != seq_prev + 8'd1) && (err_q != 16'hFFFF))
        err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lvds_rx_aligner.sv
// Bench for lvds_rx_aligner: a rotating-channel model drives training data, a scoreboard checks forwarded payload.
module tb_lvds_rx_aligner;

  localparam logic [7:0] TW     = 8'hF0;
  localparam int         MC     = 16;
  localparam int         SW     = 4;
  localparam int         PERIOD = SW + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_locked;
  logic [7:0]  rx_data;
  logic        rx_data_align;
  logic        align_done;
  logic        align_fail;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [15:0] err_cnt;

  lvds_rx_aligner #(.TRAIN_WORD(TW), .MATCH_CNT(MC), .SLIP_WAIT(SW)) dut (
    .clk(clk), .rst(rst), .rx_locked(rx_locked), .rx_data(rx_data),
    .rx_data_align(rx_data_align), .align_done(align_done), .align_fail(align_fail),
    .data_out(data_out), .data_valid(data_valid), .err_cnt(err_cnt)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         exp_t[$];
  bit         seeded    = 1'b0;
  logic [7:0] prev_fwd  = '0;
  int         err_model = 0;

  int   pulse_t[$];
  logic fail_at[$];
  logic first_done, first_valid, first_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef SEQ_CHECK_EN
    return err_model;
`else
    return 0;
`endif
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [7:0] d;
    int         t;
    if (!rst && data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: data_out %0h with nothing expected", data_out);
      end else begin
        d = exp_q.pop_front();
        t = exp_t.pop_front();
        check("data_out", data_out, d);
        check("valid_latency_cycle", cyc, t);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_word(input logic [7:0] w);
    @(posedge clk); #1;
    rx_data = w;
    if (w != TW) begin
      exp_q.push_back(w);
      exp_t.push_back(cyc + 1);
      if (seeded && w != 8'(prev_fwd + 8'd1) && err_model < 65535) err_model++;
      prev_fwd = w;
      seeded   = 1'b1;
    end
  endtask

  task automatic send_random(input int count, inout logic [7:0] last);
    int          k;
    logic [7:0]  w;
    for (int i = 0; i < count; i++) begin
      k = $urandom_range(0, 9);
      if (k < 6)      w = 8'(last + 8'd1);
      else if (k < 8) w = TW;
      else            w = 8'($urandom_range(0, 255));
      send_word(w);
      if (w != TW) last = w;
    end
  endtask

  task automatic drop_lock();
    @(posedge clk); #1;
    rx_locked = 1'b0;
    rx_data   = TW;
  endtask

  // Channel model: presents TRAIN_WORD rotated by rot; each slip pulse rotates it one step back.
  task automatic run_train(input int rot0, input bit use_const, input logic [7:0] cw,
                           input int stop_pulses, input int max_cycles,
                           output int pulses, output int hi, output int n);
    int   rot;
    logic prev_al;
    rot = rot0; prev_al = 1'b0; pulses = 0; hi = 0; n = 0;
    pulse_t.delete();
    fail_at.delete();
    @(posedge clk); #1;
    rx_locked = 1'b1;
    rx_data   = use_const ? cw : rotl(TW, rot);
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        first_done  = align_done;
        first_valid = data_valid;
        first_fail  = align_fail;
      end
      if (rx_data_align) hi++;
      if (rx_data_align && !prev_al) begin
        pulses++;
        pulse_t.push_back(n);
        fail_at.push_back(align_fail);
        rot = (rot + 7) % 8;
      end
      prev_al = rx_data_align;
      if (align_done || (stop_pulses > 0 && pulses >= stop_pulses) || n >= max_cycles) break;
      @(posedge clk); #1;
      rx_data = use_const ? cw : rotl(TW, rot);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         pulses, hi, n, r;
    logic [7:0] last;
    logic [7:0] dir_words[5];

    rst = 1'b1; rx_locked = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_align", rx_data_align, 0);
    check("reset_done", align_done, 0);
    check("reset_fail", align_fail, 0);
    check("reset_valid", data_valid, 0);
    check("reset_data", data_out, 0);
    check("reset_err", err_cnt, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_release_outputs", {rx_data_align, align_done, align_fail, data_valid, data_out}, 0);

    // Already-aligned channel: no slips.
    run_train(0, 1'b0, 8'h00, 0, 300, pulses, hi, n);
    check("a_done", align_done, 1);
    check("a_pulses", pulses, 0);
    check("a_latency", n, 2 + SW + MC);
    check("a_fail", align_fail, 0);

    // Directed payload with a dropped training word and one sequence gap.
    dir_words = '{8'h10, 8'h11, 8'hF0, 8'h12, 8'h14};
    foreach (dir_words[i]) send_word(dir_words[i]);
    send_word(TW);
    send_word(TW);
    @(negedge clk);
    check("b_err_directed", err_cnt, exp_err());

    last = 8'h14;
    send_random(60, last);
    send_word(8'h33);
    drop_lock();

    // Random starting rotation, realign after a one-cycle lock drop.
    r = $urandom_range(1, 7);
    run_train(r, 1'b0, 8'h00, 0, 400, pulses, hi, n);
    check("c_drop_done", first_done, 0);
    check("c_drop_valid", first_valid, 0);
    check("c_done", align_done, 1);
    check("c_pulses", pulses, r);
    check("c_pulse_width", hi, 2 * r);
    check("c_latency", n, 2 + r * PERIOD + SW + MC);
    check("c_fail", align_fail, 0);
    check("c_err_kept", err_cnt, exp_err());

    last = 8'h33;
    send_word(8'h34);
    last = 8'h34;
    send_random(30, last);
    send_word(TW);
    send_word(TW);
    @(negedge clk);
    check("c_err_random", err_cnt, exp_err());

    // Unalignable channel: periodic slips, sticky fail after the eighth.
    drop_lock();
    run_train(0, 1'b1, 8'h00, 9, 300, pulses, hi, n);
    check("d_pulses", pulses, 9);
    check("d_done", align_done, 0);
    check("d_pulse_hi", hi, 2 * 9 - 1);
    if (pulse_t.size() > 0) check("d_first_pulse", pulse_t[0], SW + 3);
    for (int i = 1; i < pulse_t.size(); i++) check("d_interval", pulse_t[i] - pulse_t[i-1], PERIOD);
    if (fail_at.size() >= 8) begin
      check("d_fail_7th", fail_at[6], 0);
      check("d_fail_8th", fail_at[7], 1);
    end

    // align_fail survives lock loss and clears on alignment.
    drop_lock();
    r = $urandom_range(0, 7);
    run_train(r, 1'b0, 8'h00, 0, 400, pulses, hi, n);
    check("e_fail_sticky", first_fail, 1);
    check("e_done", align_done, 1);
    check("e_pulses", pulses, r);
    check("e_fail_cleared", align_fail, 0);

    // Asynchronous reset in the middle of a slip pulse.
    drop_lock();
    run_train(0, 1'b1, 8'h00, 9, 300, pulses, hi, n);
    check("f_in_slip", rx_data_align, 1);
    check("f_fail_set", align_fail, 1);
    #1 rst = 1'b1;
    #1;
    check("f_async_align", rx_data_align, 0);
    check("f_async_outputs", {align_done, align_fail, data_valid, data_out}, 0);
    check("f_async_err", err_cnt, 0);
    err_model = 0;
    seeded    = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("f_release_outputs", {rx_data_align, align_done, align_fail, data_valid, data_out}, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
